// File: rtl/line_buffer_scheduler.sv
// line_buffer_scheduler: rotates three line BRAMs and emits aligned
// top/mid/bot column words for the 3x3 window former.
module line_buffer_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [15:0]           cfg_width,
  input  logic [15:0]           cfg_height,
  input  logic                  cfg_start,
  output logic                  busy,
  output logic                  cfg_err,
  output logic                  seq_err,
  output logic                  frame_done,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [31:0]           s_data,
  input  logic                  s_last,
  output logic [2:0]            wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [31:0]           rd_data0,
  input  logic [31:0]           rd_data1,
  input  logic [31:0]           rd_data2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_top,
  output logic [31:0]           out_mid,
  output logic [31:0]           out_bot,
  output logic                  out_eol,
  output logic                  out_last
);

  localparam int PPW = 32 / DATA_WIDTH;
  localparam logic [31:0] DEPTH = 32'd1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] col_q, col_d;
  logic [ADDR_WIDTH-1:0] wpl_m1_q, wpl_m1_d;
  logic [15:0] line_q, line_d;
  logic [15:0] hm1_q, hm1_d;
  logic [1:0] wsel_q, wsel_d;
  logic [1:0] sel_q, sel_d;
  logic cfg_err_q, cfg_err_d;
  logic seq_err_q, seq_err_d;
  logic frame_done_q, frame_done_d;
  logic out_valid_q, out_valid_d;
  logic eol_q, eol_d;
  logic last_q, last_d;
  logic [31:0] bot_q, bot_d;

  logic [31:0] wpl_cfg;
  logic cfg_bad;
  logic accept;
  logic run_acc;
  logic col_end;
  logic is_final;
  logic [1:0] top_sel;
  logic [1:0] mid_sel;

  always_comb begin
    wpl_cfg = 32'(cfg_width) / 32'(PPW);
    cfg_bad = (cfg_width == 16'd0)
           || ((32'(cfg_width) % 32'(PPW)) != 32'd0)
           || (wpl_cfg > DEPTH)
           || (cfg_height < 16'd3);
  end

  always_comb begin
    case (state_q)
      S_FILL:  s_ready = 1'b1;
      S_RUN:   s_ready = !out_valid_q || out_ready;
      default: s_ready = 1'b0;
    endcase
    accept   = s_valid && s_ready;
    run_acc  = accept && (state_q == S_RUN);
    col_end  = (col_q == wpl_m1_q);
    is_final = col_end && (line_q == hm1_q);
    wr_en    = accept ? (3'b001 << wsel_q) : 3'b000;
    wr_addr  = col_q;
    wr_data  = accept ? s_data : 32'd0;
    rd_en    = run_acc;
    rd_addr  = col_q;
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    line_d       = line_q;
    wsel_d       = wsel_q;
    wpl_m1_d     = wpl_m1_q;
    hm1_d        = hm1_q;
    sel_d        = sel_q;
    cfg_err_d    = cfg_err_q;
    seq_err_d    = seq_err_q;
    frame_done_d = 1'b0;
    out_valid_d  = out_valid_q;
    bot_d        = bot_q;
    eol_d        = eol_q;
    last_d       = last_q;
    if (accept) begin
      col_d = col_end ? '0 : col_q + 1'b1;
      if (col_end) begin
        line_d = line_q + 16'd1;
        wsel_d = (wsel_q == 2'd2) ? 2'd0 : wsel_q + 2'd1;
      end
      if (s_last != is_final) seq_err_d = 1'b1;
    end
    // mux select is captured with the accept, before wsel rotates
    if (run_acc) begin
      out_valid_d = 1'b1;
      bot_d       = s_data;
      eol_d       = col_end;
      last_d      = is_final;
      sel_d       = wsel_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      eol_d       = 1'b0;
      last_d      = 1'b0;
    end
    case (state_q)
      S_IDLE: begin
        if (cfg_start && !frame_done_q) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d   = S_FILL;
            col_d     = '0;
            line_d    = 16'd0;
            wsel_d    = 2'd0;
            cfg_err_d = 1'b0;
            seq_err_d = 1'b0;
            wpl_m1_d  = ADDR_WIDTH'(wpl_cfg - 32'd1);
            hm1_d     = cfg_height - 16'd1;
          end
        end
      end
      S_FILL: begin
        if (accept && col_end && line_q == 16'd1) state_d = S_RUN;
      end
      S_RUN: begin
        if (accept && is_final) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (out_valid_q && out_ready) begin
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      line_q       <= 16'd0;
      wsel_q       <= 2'd0;
      wpl_m1_q     <= '0;
      hm1_q        <= 16'd0;
      sel_q        <= 2'd0;
      cfg_err_q    <= 1'b0;
      seq_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
      out_valid_q  <= 1'b0;
      bot_q        <= 32'd0;
      eol_q        <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      line_q       <= line_d;
      wsel_q       <= wsel_d;
      wpl_m1_q     <= wpl_m1_d;
      hm1_q        <= hm1_d;
      sel_q        <= sel_d;
      cfg_err_q    <= cfg_err_d;
      seq_err_q    <= seq_err_d;
      frame_done_q <= frame_done_d;
      out_valid_q  <= out_valid_d;
      bot_q        <= bot_d;
      eol_q        <= eol_d;
      last_q       <= last_d;
    end
  end

  // line k sits in buffer k mod 3, so top is sel+1 and mid is sel+2
  always_comb begin
    top_sel = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
    mid_sel = (sel_q == 2'd0) ? 2'd2 : sel_q - 2'd1;
    out_top = 32'd0;
    out_mid = 32'd0;
    if (out_valid_q) begin
      case (top_sel)
        2'd0:    out_top = rd_data0;
        2'd1:    out_top = rd_data1;
        default: out_top = rd_data2;
      endcase
      case (mid_sel)
        2'd0:    out_mid = rd_data0;
        2'd1:    out_mid = rd_data1;
        default: out_mid = rd_data2;
      endcase
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign cfg_err    = cfg_err_q;
  assign seq_err    = seq_err_q;
  assign frame_done = frame_done_q;
  assign out_valid  = out_valid_q;
  assign out_bot    = bot_q;
  assign out_eol    = eol_q;
  assign out_last   = last_q;

endmodule

// File: tb/tb_line_buffer_scheduler.sv
// tb_line_buffer_scheduler: random/directed frames against a
// row-array reference model of the three-line window.
module tb_line_buffer_scheduler;

  localparam int AW = 4;

  typedef logic [97:0] rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] cfg_width = 16'd0;
  logic [15:0] cfg_height = 16'd0;
  logic cfg_start = 1'b0;
  logic busy, cfg_err, seq_err, frame_done;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [31:0] s_data = 32'd0;
  logic s_last = 1'b0;
  logic [2:0] wr_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [31:0] wr_data;
  logic rd_en;
  logic [31:0] rd0, rd1, rd2;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [31:0] out_top, out_mid, out_bot;
  logic out_eol, out_last;

  logic [31:0] mem0 [16];
  logic [31:0] mem1 [16];
  logic [31:0] mem2 [16];

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int fd_count = 0;
  int fd_cyc = 0;
  int xfer_cyc = 0;
  int sent = 0;
  int rdy_mode = 0;
  bit abort = 1'b0;

  logic [31:0] img[$];
  rec_t got[$];
  rec_t exp_q[$];
  logic [2:0] wen_q[$];

  line_buffer_scheduler #(.DATA_WIDTH(8), .ADDR_WIDTH(AW)) dut (
    .Clk(clk), .Rst(rst),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_start(cfg_start), .busy(busy),
    .cfg_err(cfg_err), .seq_err(seq_err),
    .frame_done(frame_done),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data0(rd0), .rd_data1(rd1), .rd_data2(rd2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_top(out_top), .out_mid(out_mid), .out_bot(out_bot),
    .out_eol(out_eol), .out_last(out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (wr_en[0]) mem0[wr_addr] <= wr_data;
    if (wr_en[1]) mem1[wr_addr] <= wr_data;
    if (wr_en[2]) mem2[wr_addr] <= wr_data;
    if (rd_en) begin
      rd0 <= mem0[rd_addr];
      rd1 <= mem1[rd_addr];
      rd2 <= mem2[rd_addr];
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = ($urandom % 4) != 0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        got.push_back({out_top, out_mid, out_bot, out_eol, out_last});
        xfer_cyc = cyc;
      end
      if (frame_done) begin
        fd_count++;
        fd_cyc = cyc;
      end
    end
  end

  function automatic void fill_img(int n, bit rnd);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back(rnd ? $urandom : 32'(i));
  endfunction

  // window rows k-2, k-1, k at column c for every line k >= 2
  function automatic void build_exp(int wpl, int h);
    exp_q.delete();
    for (int k = 2; k < h; k++)
      for (int c = 0; c < wpl; c++)
        exp_q.push_back({img[(k-2)*wpl+c], img[(k-1)*wpl+c], img[k*wpl+c],
                         (c == wpl - 1), (k == h - 1 && c == wpl - 1)});
  endfunction

  task automatic start_frame(int w, int h);
    got.delete();
    wen_q.delete();
    fd_count = 0;
    sent = 0;
    @(posedge clk); #1;
    cfg_width = 16'(w);
    cfg_height = 16'(h);
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic send_frame(int lastpos, bit gaps);
    for (int i = 0; i < img.size(); i++) begin
      int tries;
      logic acc;
      if (abort) break;
      if (gaps && ($urandom % 3) == 0) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data = img[i];
      s_last = (i == lastpos);
      tries = 0;
      acc = 1'b0;
      while (!acc && tries < 500 && !abort) begin
        @(negedge clk);
        acc = s_ready;
        if (acc) wen_q.push_back(wr_en);
        @(posedge clk); #1;
        tries++;
      end
      if (abort) break;
      if (!acc) begin
        n_tests++; n_fail++;
        $display("FAIL send_timeout word=%0d got=not_accepted exp=accepted", i);
        break;
      end
      sent = i + 1;
    end
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && fd_count == 0; i++) @(negedge clk);
    n_tests++;
    if (fd_count == 0) begin
      n_fail++;
      $display("FAIL done_timeout got=no_frame_done exp=frame_done");
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    s_valid = 1'b1;
    s_data = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #2;
    n_tests++;
    if ({s_ready, wr_en, rd_en, out_valid, out_eol, out_last, busy,
         frame_done, cfg_err, seq_err} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b exp=0", {s_ready, wr_en, rd_en,
               out_valid, out_eol, out_last, busy, frame_done, cfg_err, seq_err});
    end
    n_tests++;
    if ({out_top, out_mid, out_bot, wr_data, wr_addr, rd_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_data got=%h exp=0",
               {out_top, out_mid, out_bot, wr_data, wr_addr, rd_addr});
    end
    s_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    rdy_mode = 0;
    fill_img(16, 1'b0);
    build_exp(4, 4);
    start_frame(16, 4);
    send_frame(15, 1'b0);
    wait_done();
    n_tests++;
    if (got.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL basic_count got=%0d exp=%0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL basic_word%0d got=%h exp=%h", i,
                 (i < got.size()) ? got[i] : 98'h0, exp_q[i]);
      end
    end
    n_tests++;
    if (fd_count != 1 || fd_cyc != xfer_cyc + 1) begin
      n_fail++;
      $display("FAIL basic_done got=cnt%0d@%0d exp=cnt1@%0d",
               fd_count, fd_cyc, xfer_cyc + 1);
    end
    n_tests++;
    if ({busy, cfg_err, seq_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL basic_flags got=%b exp=000", {busy, cfg_err, seq_err});
    end
  endtask

  task automatic test_rotation();
    rdy_mode = 0;
    fill_img(6, 1'b0);
    build_exp(1, 6);
    start_frame(4, 6);
    send_frame(5, 1'b0);
    wait_done();
    n_tests++;
    if (got.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rot_count got=%0d exp=%0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rot_word%0d got=%h exp=%h", i,
                 (i < got.size()) ? got[i] : 98'h0, exp_q[i]);
      end
    end
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (i >= wen_q.size() || wen_q[i] !== 3'(1 << (i % 3))) begin
        n_fail++;
        $display("FAIL rot_wr_en%0d got=%b exp=%b", i,
                 (i < wen_q.size()) ? wen_q[i] : 3'b000, 3'(1 << (i % 3)));
      end
    end
  endtask

  task automatic test_backpressure();
    rdy_mode = 2;
    out_ready = 1'b1;
    fill_img(16, 1'b1);
    build_exp(4, 4);
    start_frame(16, 4);
    fork
      send_frame(15, 1'b0);
      begin
        rec_t snap;
        bit bad_hs;
        bit bad_st;
        bad_hs = 1'b0;
        bad_st = 1'b0;
        for (int k = 0; k < 500; k++) begin
          @(posedge clk); #2;
          if (got.size() == 2 && out_valid) break;
        end
        out_ready = 1'b0;
        @(negedge clk);
        snap = {out_top, out_mid, out_bot, out_eol, out_last};
        for (int k = 0; k < 5; k++) begin
          if (k > 0) @(negedge clk);
          if (s_ready !== 1'b0 || rd_en !== 1'b0) bad_hs = 1'b1;
          if ({out_top, out_mid, out_bot, out_eol, out_last} !== snap ||
              out_valid !== 1'b1) bad_st = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        n_tests++;
        if (bad_hs) begin
          n_fail++;
          $display("FAIL bp_handshake got=ready_or_rd_en_high exp=low");
        end
        n_tests++;
        if (bad_st) begin
          n_fail++;
          $display("FAIL bp_stable got=changed exp=held snap=%h", snap);
        end
      end
    join
    wait_done();
    n_tests++;
    if (got.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL bp_count got=%0d exp=%0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL bp_word%0d got=%h exp=%h", i,
                 (i < got.size()) ? got[i] : 98'h0, exp_q[i]);
      end
    end
    rdy_mode = 0;
  endtask

  task automatic test_bad_config();
    int ws[3] = '{18, 16, 68};
    int hs[3] = '{4, 2, 4};
    for (int t = 0; t < 3; t++) begin
      bit moved;
      start_frame(ws[t], hs[t]);
      s_valid = 1'b1;
      moved = 1'b0;
      repeat (3) begin
        @(negedge clk);
        if (s_ready !== 1'b0 || busy !== 1'b0) moved = 1'b1;
      end
      n_tests++;
      if (cfg_err !== 1'b1 || moved) begin
        n_fail++;
        $display("FAIL badcfg%0d got=err%b moved%0d exp=err1 moved0",
                 t, cfg_err, moved);
      end
      s_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_early_last();
    rdy_mode = 0;
    fill_img(16, 1'b1);
    build_exp(4, 4);
    start_frame(16, 4);
    n_tests++;
    if (cfg_err !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL early_start got=err%b busy%b exp=err0 busy1", cfg_err, busy);
    end
    send_frame(10, 1'b0);
    wait_done();
    n_tests++;
    if (seq_err !== 1'b1 || fd_count != 1) begin
      n_fail++;
      $display("FAIL early_seq got=seq%b done%0d exp=seq1 done1",
               seq_err, fd_count);
    end
    n_tests++;
    if (got !== exp_q) begin
      n_fail++;
      $display("FAIL early_data got=%0d_words exp=%0d_words",
               got.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    rdy_mode = 0;
    fill_img(16, 1'b1);
    start_frame(16, 4);
    fork
      send_frame(15, 1'b0);
      begin
        for (int k = 0; k < 500 && sent < 9; k++) @(negedge clk);
        @(posedge clk); #3;
        rst = 1'b1;
        abort = 1'b1;
        #1;
        n_tests++;
        if ({s_ready, wr_en, rd_en, out_valid, out_eol, out_last, busy,
             frame_done, cfg_err, seq_err, out_top, out_mid, out_bot,
             wr_data, wr_addr, rd_addr} !== '0) begin
          n_fail++;
          $display("FAIL midrst_zero got=busy%b vld%b top=%h bot=%h exp=0",
                   busy, out_valid, out_top, out_bot);
        end
        @(negedge clk); #2;
        rst = 1'b0;
      end
    join
    abort = 1'b0;
    fill_img(16, 1'b1);
    build_exp(4, 4);
    start_frame(16, 4);
    send_frame(15, 1'b0);
    wait_done();
    n_tests++;
    if (got !== exp_q || fd_count != 1 || seq_err !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_frame got=%0d_words done%0d exp=%0d_words done1",
               got.size(), fd_count, exp_q.size());
    end
  endtask

  task automatic test_done_start();
    rdy_mode = 0;
    fill_img(16, 1'b1);
    start_frame(16, 4);
    fork
      send_frame(15, 1'b0);
      begin
        for (int k = 0; k < 500 && frame_done !== 1'b1; k++) @(negedge clk);
        cfg_width = 16'd16;
        cfg_height = 16'd4;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || fd_count != 1) begin
          n_fail++;
          $display("FAIL done_start got=busy%b done%0d exp=busy0 done1",
                   busy, fd_count);
        end
      end
    join
  endtask

  task automatic test_random();
    rdy_mode = 1;
    for (int it = 0; it < 5; it++) begin
      int wpl;
      int h;
      wpl = (it == 0) ? 16 : int'($urandom_range(1, 16));
      h = int'($urandom_range(3, 5));
      fill_img(wpl * h, 1'b1);
      build_exp(wpl, h);
      start_frame(wpl * 4, h);
      send_frame(wpl * h - 1, 1'b1);
      wait_done();
      n_tests++;
      if (got !== exp_q || fd_count != 1 || fd_cyc != xfer_cyc + 1) begin
        n_fail++;
        $display("FAIL rand%0d wpl=%0d h=%0d got=%0d_words done%0d exp=%0d_words",
                 it, wpl, h, got.size(), fd_count, exp_q.size());
      end
      n_tests++;
      if ({seq_err, cfg_err, busy} !== 3'b000) begin
        n_fail++;
        $display("FAIL rand%0d_flags got=%b exp=000", it,
                 {seq_err, cfg_err, busy});
      end
    end
    rdy_mode = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rotation();
    test_backpressure();
    test_bad_config();
    test_early_last();
    test_reset_mid_frame();
    test_done_start();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
